arrow_lane_engine: RTL and testbench



---
 rtl/arrow_lane_engine.sv | 200 ++++++++++++++++++++
 tb/tb_arrow_lane_engine.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/arrow_lane_engine.sv
// Arrow engine for the rhythm-game display. Each lane holds SLOTS arrows that
// move up the screen on the frame tick. The engine judges button presses
// against a target zone, pulses hit/miss/bad per lane, keeps a saturating
// score and combo, and drives a registered pixel mask per lane.
module arrow_lane_engine #(
    parameter int CORDW      = 10,
    parameter int LANES      = 4,
    parameter int SLOTS      = 4,
    parameter int ARROW_SIZE = 50,
    parameter int ARROW_GAP  = 10,
    parameter int X_BEGIN    = 197,
    parameter int Y_BEGIN    = 450,
    parameter int SPEED      = 7,
    parameter int TARGET_Y   = 50,
    parameter int HIT_WIN    = 20,
    parameter int SCOREW     = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [CORDW-1:0]  sx_i,
    input  logic [CORDW-1:0]  sy_i,
    input  logic              frame_i,
    input  logic [LANES-1:0]  launch_i,
    input  logic [LANES-1:0]  btn_i,
    output logic [LANES-1:0]  arrow_o,
    output logic [LANES-1:0]  hit_o,
    output logic [LANES-1:0]  miss_o,
    output logic [LANES-1:0]  bad_o,
    output logic              overflow_o,
    output logic [SCOREW-1:0] score_o,
    output logic [SCOREW-1:0] combo_o
);

    // One extra bit so window and miss comparisons never underflow.
    localparam int XW  = CORDW + 1;
    localparam int SW1 = SCOREW + 1;
    localparam int CNTW = $clog2(LANES + 1);

    localparam logic [XW-1:0]    WIN_LO  = XW'(TARGET_Y - HIT_WIN);
    localparam logic [XW-1:0]    WIN_HI  = XW'(TARGET_Y + HIT_WIN);
    localparam logic [XW-1:0]    MISS_TH = XW'(TARGET_Y - HIT_WIN + SPEED);
    localparam logic [XW-1:0]    SIZE_X  = XW'(ARROW_SIZE);
    localparam logic [CORDW-1:0] Y_SPAWN = CORDW'(Y_BEGIN);
    localparam logic [CORDW-1:0] STEP    = CORDW'(SPEED);

    logic [SLOTS-1:0] valid_q [LANES];
    logic [SLOTS-1:0] valid_d [LANES];
    logic [CORDW-1:0] y_q     [LANES][SLOTS];
    logic [CORDW-1:0] y_d     [LANES][SLOTS];

    logic [LANES-1:0]  btn_q;
    logic [LANES-1:0]  press;
    logic [LANES-1:0]  hit_d;
    logic [LANES-1:0]  miss_d;
    logic [LANES-1:0]  bad_d;
    logic [LANES-1:0]  arrow_d;
    logic              ovf_d;
    logic [SLOTS-1:0]  hit_sel;
    logic [SLOTS-1:0]  free_sel;
    logic              hit_taken;
    logic              free_taken;
    logic [CNTW-1:0]   hit_cnt;
    logic [SW1-1:0]    score_sum;
    logic [SW1-1:0]    combo_sum;
    logic [SCOREW-1:0] score_d;
    logic [SCOREW-1:0] combo_d;

    function automatic logic [XW-1:0] lane_x(input int unsigned k);
        return XW'(X_BEGIN + int'(k) * (ARROW_SIZE + ARROW_GAP));
    endfunction

    assign press = btn_i & ~btn_q;

    // Per-lane judging: hit, then move/miss, then launch, all on pre-update state.
    always_comb begin
        valid_d    = valid_q;
        y_d        = y_q;
        hit_d      = '0;
        miss_d     = '0;
        bad_d      = '0;
        ovf_d      = overflow_o;
        hit_sel    = '0;
        free_sel   = '0;
        hit_taken  = 1'b0;
        free_taken = 1'b0;
        for (int unsigned k = 0; k < LANES; k++) begin
            hit_sel    = '0;
            free_sel   = '0;
            hit_taken  = 1'b0;
            free_taken = 1'b0;
            for (int unsigned s = 0; s < SLOTS; s++) begin
                if (!hit_taken && press[k] && valid_q[k][s] &&
                    ({1'b0, y_q[k][s]} >= WIN_LO) && ({1'b0, y_q[k][s]} <= WIN_HI)) begin
                    hit_sel[s] = 1'b1;
                    hit_taken  = 1'b1;
                end
                if (!free_taken && !valid_q[k][s]) begin
                    free_sel[s] = 1'b1;
                    free_taken  = 1'b1;
                end
            end
            if (press[k]) begin
                hit_d[k] = hit_taken;
                bad_d[k] = ~hit_taken;
            end
            for (int unsigned s = 0; s < SLOTS; s++) begin
                if (hit_sel[s]) begin
                    valid_d[k][s] = 1'b0;
                end else if (frame_i && valid_q[k][s]) begin
                    if ({1'b0, y_q[k][s]} < MISS_TH) begin
                        valid_d[k][s] = 1'b0;
                        miss_d[k]     = 1'b1;
                    end else begin
                        y_d[k][s] = y_q[k][s] - STEP;
                    end
                end
                // Launch targets a slot that was free before this cycle, so it
                // never collides with a slot being hit or moved.
                if (launch_i[k] && free_sel[s]) begin
                    valid_d[k][s] = 1'b1;
                    y_d[k][s]     = Y_SPAWN;
                end
            end
            if (launch_i[k] && !free_taken) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Saturating score and combo update from this cycle's pulses.
    always_comb begin
        hit_cnt = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            hit_cnt = hit_cnt + CNTW'(hit_d[k]);
        end
        score_sum = {1'b0, score_o} + SW1'(hit_cnt);
        combo_sum = {1'b0, combo_o} + SW1'(hit_cnt);
        score_d   = score_sum[SCOREW] ? '1 : score_sum[SCOREW-1:0];
        if ((|miss_d) || (|bad_d)) begin
            combo_d = '0;
        end else begin
            combo_d = combo_sum[SCOREW] ? '1 : combo_sum[SCOREW-1:0];
        end
    end

    // Pixel hit test of every valid slot against the current beam position.
    always_comb begin
        arrow_d = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            for (int unsigned s = 0; s < SLOTS; s++) begin
                if (valid_q[k][s] &&
                    ({1'b0, sx_i} >= lane_x(k)) &&
                    ({1'b0, sx_i} <  lane_x(k) + SIZE_X) &&
                    ({1'b0, sy_i} >= {1'b0, y_q[k][s]}) &&
                    ({1'b0, sy_i} <  {1'b0, y_q[k][s]} + SIZE_X)) begin
                    arrow_d[k] = 1'b1;
                end
            end
        end
    end

    // Slot state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                valid_q[k] <= '0;
                for (int unsigned s = 0; s < SLOTS; s++) begin
                    y_q[k][s] <= '0;
                end
            end
        end else begin
            valid_q <= valid_d;
            y_q     <= y_d;
        end
    end

    // Output and button-history registers; btn_q resets high so a held button is not a press.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            btn_q      <= '1;
            arrow_o    <= '0;
            hit_o      <= '0;
            miss_o     <= '0;
            bad_o      <= '0;
            overflow_o <= 1'b0;
            score_o    <= '0;
            combo_o    <= '0;
        end else begin
            btn_q      <= btn_i;
            arrow_o    <= arrow_d;
            hit_o      <= hit_d;
            miss_o     <= miss_d;
            bad_o      <= bad_d;
            overflow_o <= ovf_d;
            score_o    <= score_d;
            combo_o    <= combo_d;
        end
    end

endmodule

// File: tb/tb_arrow_lane_engine.sv
// Directed bench for arrow_lane_engine: each step pushes its expected outputs
// to a scoreboard queue, and the entry is popped and checked after the edge.
module tb_arrow_lane_engine;

    localparam int SW   = 3;
    localparam int SMAX = (1 << SW) - 1;

    localparam logic [3:0] N  = 4'b0000;
    localparam logic [3:0] L0 = 4'b0001;
    localparam logic [3:0] L1 = 4'b0010;
    localparam logic [3:0] L2 = 4'b0100;
    localparam logic [3:0] L3 = 4'b1000;
    localparam logic [9:0] Z  = 10'd0;

    typedef struct {
        string      tag;
        logic [3:0] arrow;
        logic [3:0] hit;
        logic [3:0] miss;
        logic [3:0] bad;
        logic       ovf;
        int         score;
        int         combo;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [9:0]    sx, sy;
    logic          frame;
    logic [3:0]    launch, btn;
    logic [3:0]    arrow, hit, miss, bad;
    logic          ovf;
    logic [SW-1:0] score, combo;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_score = 0;
    int   exp_combo = 0;
    logic exp_ovf = 1'b0;

    arrow_lane_engine #(.SCOREW(SW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .sx_i       (sx),
        .sy_i       (sy),
        .frame_i    (frame),
        .launch_i   (launch),
        .btn_i      (btn),
        .arrow_o    (arrow),
        .hit_o      (hit),
        .miss_o     (miss),
        .bad_o      (bad),
        .overflow_o (ovf),
        .score_o    (score),
        .combo_o    (combo)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v);
        return (v > SMAX) ? SMAX : v;
    endfunction

    task automatic cmp(input string tag, input string what,
                       input logic [15:0] got, input logic [15:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s %s: got %0h expected %0h", tag, what, got, want);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: got empty queue expected one entry");
            return;
        end
        e = sb.pop_front();
        cmp(e.tag, "arrow", 16'(arrow), 16'(e.arrow));
        cmp(e.tag, "hit",   16'(hit),   16'(e.hit));
        cmp(e.tag, "miss",  16'(miss),  16'(e.miss));
        cmp(e.tag, "bad",   16'(bad),   16'(e.bad));
        cmp(e.tag, "ovf",   16'(ovf),   16'(e.ovf));
        cmp(e.tag, "score", 16'(score), 16'(e.score));
        cmp(e.tag, "combo", 16'(combo), 16'(e.combo));
    endtask

    // Drive one cycle of stimulus, queue the outputs expected after the edge, then check.
    task automatic step(input string tag, input logic [3:0] l, input logic [3:0] b,
                        input logic f, input logic [9:0] x, input logic [9:0] y,
                        input logic [3:0] eh, input logic [3:0] em,
                        input logic [3:0] eb, input logic [3:0] ea);
        exp_t e;
        launch = l;
        btn    = b;
        frame  = f;
        sx     = x;
        sy     = y;
        if (!rst_n) begin
            exp_score = 0;
            exp_combo = 0;
            exp_ovf   = 1'b0;
            e = '{tag, N, N, N, N, 1'b0, 0, 0};
        end else begin
            exp_score = sat(exp_score + $countones(eh));
            if (em != N || eb != N) exp_combo = 0;
            else                    exp_combo = sat(exp_combo + $countones(eh));
            e = '{tag, ea, eh, em, eb, exp_ovf, exp_score, exp_combo};
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic frames(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step(tag, N, N, 1'b1, Z, Z, N, N, N, N);
        end
    endtask

    task automatic idle(input string tag);
        step(tag, N, N, 1'b0, Z, Z, N, N, N, N);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; sx = Z; sy = Z; frame = 1'b0; launch = N; btn = N;
        // reset with lane 0 button held; release reset with it still held
        step("rst0", N, L0, 1'b0, Z, Z, N, N, N, N);
        step("rst1", N, L0, 1'b0, Z, Z, N, N, N, N);
        rst_n = 1'b1;
        step("held", N, L0, 1'b0, Z, Z, N, N, N, N);
        idle("held_rel");

        // single arrow lane 0: 55 frames to y=65, then hit
        step("a_launch", L0, N, 1'b0, Z, Z, N, N, N, N);
        frames("a_move", 55);
        step("a_hit", N, L0, 1'b0, Z, Z, L0, N, N, N);
        step("a_hold", N, L0, 1'b0, Z, Z, N, N, N, N);
        idle("a_rel");

        // unhit arrow lane 2: 60 frames to y=30 without miss, frame 61 misses
        step("c_launch", L2, N, 1'b0, Z, Z, N, N, N, N);
        frames("c_move", 60);
        step("c_miss", N, N, 1'b1, Z, Z, N, L2, N, N);
        idle("c_after");

        // coincident frame+press+launch on lane 0 with arrow at y=51
        step("e_launch", L0, N, 1'b0, Z, Z, N, N, N, N);
        frames("e_move", 57);
        step("e_coinc", L0, L0, 1'b1, Z, Z, L0, N, N, N);
        step("e_draw", L1, N, 1'b0, 10'd197, 10'd450, N, N, N, L0);
        frames("e_move2", 55);
        step("e_hit2", N, 4'b0011, 1'b0, Z, Z, 4'b0011, N, N, N);
        idle("e_rel");

        // bad press lane 1 with arrow at y=450: combo 3 -> 0
        step("d_launch", L1, N, 1'b0, Z, Z, N, N, N, N);
        step("d_bad", N, L1, 1'b0, Z, Z, N, N, L1, N);
        idle("d_rel");

        // draw lane 1 at y=100 with x/y edges
        frames("f_move", 50);
        step("f_in",     N, N, 1'b0, 10'd257, 10'd100, N, N, N, L1);
        step("f_xedge",  N, N, 1'b0, 10'd307, 10'd100, N, N, N, N);
        step("f_corner", N, N, 1'b0, 10'd306, 10'd149, N, N, N, L1);
        step("f_yedge",  N, N, 1'b0, 10'd306, 10'd150, N, N, N, N);
        step("f_above",  N, N, 1'b0, 10'd257, 10'd99,  N, N, N, N);
        step("f_left",   N, N, 1'b0, 10'd256, 10'd120, N, N, N, N);
        frames("f_move2", 5);
        step("f_hit", N, L1, 1'b0, Z, Z, L1, N, N, N);
        idle("f_rel");

        // overflow lane 3: five launches, four slots
        for (int i = 0; i < 4; i++) begin
            step("b_launch", L3, N, 1'b0, Z, Z, N, N, N, N);
        end
        exp_ovf = 1'b1;
        step("b_ovf", L3, N, 1'b0, Z, Z, N, N, N, N);
        step("b_draw", N, N, 1'b0, 10'd377, 10'd450, N, N, N, L3);
        frames("b_move", 55);
        // four hits drain the four slots; score saturates at SMAX
        for (int i = 0; i < 4; i++) begin
            step("b_hit", N, L3, 1'b0, Z, Z, L3, N, N, N);
            idle("b_rel");
        end
        step("b_empty", N, L3, 1'b0, Z, Z, N, N, L3, N);
        idle("b_rel2");

        // reset mid-frame with live arrow in lane 2
        step("g_launch", L2, N, 1'b0, Z, Z, N, N, N, N);
        frames("g_move", 2);
        step("g_draw", N, N, 1'b0, 10'd317, 10'd436, N, N, N, L2);
        rst_n = 1'b0;
        step("g_rst", L2, N, 1'b1, 10'd317, 10'd436, N, N, N, N);
        rst_n = 1'b1;
        step("g_empty", N, N, 1'b0, 10'd317, 10'd436, N, N, N, N);
        step("g_nobad", N, N, 1'b0, 10'd317, 10'd436, N, N, N, N);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
